// File: rtl/board_judge.sv
`default_nettype none
// ============================================================================
// Module   : board_judge
// Purpose  : Tic-tac-toe judge stage. On an accepted request it snapshots the
//            3x3 board, scans the 8 winning lines one per cycle, then checks
//            for a full board and for overlapping cells. Results are held
//            stable until the next accepted request.
// Ports    : clk, reset (async, active-high)
//            make_judge_req   - request pulse, accepted while ready is high
//            make_judge_ready - (state==IDLE) & ~make_judge_req
//            board_a/board_b  - 9-bit cell masks, bit index = row*3+col
//            end_of_game, win_a, win_b, draw, board_error, win_line[2:0]
// Revision : 1.0 - initial release
// ============================================================================
module board_judge #(
  parameter int EARLY_EXIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       make_judge_req,
  output logic       make_judge_ready,
  input  logic [8:0] board_a,
  input  logic [8:0] board_b,
  output logic       end_of_game,
  output logic       win_a,
  output logic       win_b,
  output logic       draw,
  output logic       board_error,
  output logic [2:0] win_line
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [8:0] snap_a;
  logic [8:0] snap_b;
  logic [2:0] li;

  logic [8:0] cur_mask;
  logic       hit_a;
  logic       hit_b;
  logic       scan_done;
  logic       full;
  logic       overlap;
  logic       draw_next;

  // Cell mask of winning line idx: rows, then columns, then the two diagonals.
  function automatic logic [8:0] line_mask(input logic [2:0] idx);
    logic [8:0] m;
    case (idx)
      3'd0:    m = 9'b000_000_111;
      3'd1:    m = 9'b000_111_000;
      3'd2:    m = 9'b111_000_000;
      3'd3:    m = 9'b001_001_001;
      3'd4:    m = 9'b010_010_010;
      3'd5:    m = 9'b100_100_100;
      3'd6:    m = 9'b100_010_001;
      default: m = 9'b001_010_100;
    endcase
    return m;
  endfunction

  assign cur_mask  = line_mask(li);
  assign hit_a     = ((snap_a & cur_mask) == cur_mask);
  assign hit_b     = ((snap_b & cur_mask) == cur_mask);
  // Last line reached, or an early win ends the scan when enabled.
  assign scan_done = (li == 3'd7) || ((EARLY_EXIT != 0) && (hit_a || hit_b));

  assign full      = &(snap_a | snap_b);
  assign overlap   = |(snap_a & snap_b);
  assign draw_next = full & ~win_a & ~win_b;

  // Ready drops in the request cycle itself so the upstream manager, which
  // samples ready one cycle after raising req, never sees a stale idle.
  assign make_judge_ready = (state == IDLE) & ~make_judge_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (make_judge_req) state_next = SCAN;
      SCAN:    if (scan_done)      state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_a      <= 9'd0;
      snap_b      <= 9'd0;
      li          <= 3'd0;
      end_of_game <= 1'b0;
      win_a       <= 1'b0;
      win_b       <= 1'b0;
      draw        <= 1'b0;
      board_error <= 1'b0;
      win_line    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (make_judge_req) begin
            snap_a      <= board_a;
            snap_b      <= board_b;
            li          <= 3'd0;
            end_of_game <= 1'b0;
            win_a       <= 1'b0;
            win_b       <= 1'b0;
            draw        <= 1'b0;
            board_error <= 1'b0;
            win_line    <= 3'd0;
          end
        end
        SCAN: begin
          if (hit_a) win_a <= 1'b1;
          if (hit_b) win_b <= 1'b1;
          // Only the first (lowest-numbered) won line is recorded.
          if ((hit_a || hit_b) && !(win_a || win_b)) win_line <= li;
          if (!scan_done) li <= li + 3'd1;
        end
        FINAL: begin
          board_error <= overlap;
          draw        <= draw_next;
          end_of_game <= win_a | win_b | draw_next | overlap;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/board_judge.md
Name: board_judge

Overview:
- Judge stage fed by the game manager's make_judge_req/make_judge_ready handshake.
- On each accepted request it snapshots the 3x3 board and scans the 8 winning lines sequentially, one per cycle.
- It then checks for a full board and for an illegal (overlapping) board.
- It returns end_of_game, win_a, win_b and auxiliary flags, held stable until the next request.

Parameters:
- EARLY_EXIT, 0, 1 = stop the scan at the first line won by either player; 0 = always scan all 8 lines.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- make_judge_req  input  1  one-cycle request pulse; accepted when high in a cycle where make_judge_ready is high
- make_judge_ready  output  1  idle/results-valid indicator (combinational, see Behaviour)
- board_a  input  9  cell mask for player A; bit index = row*3+col
- board_b  input  9  cell mask for player B, same indexing
- end_of_game  output  1  win_a | win_b | draw | board_error
- win_a  output  1  player A owns at least one complete line
- win_b  output  1  player B owns at least one complete line
- draw  output  1  board full and no winner
- board_error  output  1  some cell is set in both board_a and board_b
- win_line  output  3  index 0..7 of the lowest-numbered won line; 0 if none

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all result outputs and win_line = 0.
  - make_judge_ready follows its combinational rule, so it is 1 after reset unless req is high.
  - Reset asserted mid-scan aborts the scan immediately; no partial results are kept.
- States:
  - IDLE: wait for a request.
  - SCAN: line counter li runs 0..7.
  - FINAL: compute draw/end_of_game.
- make_judge_ready = (state==IDLE) & ~make_judge_req.
  - The upstream manager registers req and samples ready in the following cycle, so ready must read 0 in the request cycle itself.
- Accept (IDLE & req at a clock edge):
  - Latch board_a/board_b into internal snapshot registers.
  - Clear all result outputs and win_line to 0; set li=0; go to SCAN.
  - Board inputs may change freely after the accept edge.
- req while state!=IDLE: ignored; no queuing.
- Line table:
  - li 0-2 = rows {0,1,2},{3,4,5},{6,7,8}.
  - li 3-5 = columns {0,3,6},{1,4,7},{2,5,8}.
  - li 6 = {0,4,8}; li 7 = {2,4,6}.
- SCAN, one line per cycle:
  - If all 3 snapshot A bits of line li are set: win_a<=1.
  - If all 3 snapshot B bits of line li are set: win_b<=1.
  - On the first win seen, win_line<=li; later wins do not overwrite it.
  - li==7: go to FINAL.
  - EARLY_EXIT=1 and a win detected this cycle: go to FINAL without scanning further lines.
- FINAL (one cycle):
  - full = &(snapA|snapB).
  - board_error <= |(snapA&snapB).
  - draw <= full & ~win_a & ~win_b (using the final win values).
  - end_of_game <= any of win_a, win_b, draw, board_error.
  - Go to IDLE.
- Latency, request accepted at edge E:
  - EARLY_EXIT=0: ready returns 1 in the cycle after edge E+9 (8 SCAN + 1 FINAL); results valid from then on.
  - EARLY_EXIT=1: fewer cycles if a win is found early.
- Results hold unchanged in IDLE until the next accept.
- Both players winning (illegal board): both win flags set, end_of_game=1; board_error set only if cells overlap.
- Empty board: all flags 0; game continues.

Test Plan:
- Reset then board_a=0,board_b=0, req pulse -> ready 0 in the req cycle and for 9 cycles after accept, then 1; all flags 0; win_line=0.
- board_a=9'b000_000_111 (top row), board_b=9'b000_011_000, req -> win_a=1, win_b=0, end_of_game=1, win_line=0.
- board_b=9'b100_010_001 (main diagonal), board_a=9'b011_001_000 -> win_b=1, win_line=6, draw=0, end_of_game=1.
- Full board, no line: board_a=9'b010_110_001, board_b=9'b101_001_110 -> draw=1, end_of_game=1, wins 0.
- Overlap: board_a=9'b000_000_001, board_b=9'b000_000_001 -> board_error=1, end_of_game=1. Also check that a second req pulse issued mid-scan is ignored: total latency stays 9.
- Assert reset at SCAN li=4 -> immediate IDLE, outputs 0, ready=1. EARLY_EXIT=1 with the top-row A win -> ready returns 2 cycles after accept, with win_line=0.
